// File: rtl/nlfsr3_seq_ctrl.sv
// Sequencer for the NLFSR3 warbler stage: takes a seed and tweak, shifts the seed in,
// runs the init rounds, then packs keystream bits into words on a valid/ready output.
module nlfsr3_seq_ctrl #(
  parameter int unsigned INIT_CYCLES = 54,
  parameter int unsigned OUT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [29:0]      seed_data,
  input  logic [4:0]       seed_tk,
  output logic             nlfsr3_ce,
  output logic             load,
  output logic             init,
  output logic [4:0]       d3,
  output logic [4:0]       tk,
  input  logic             o_warbler,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [OUT_W-1:0] rnd_data,
  output logic             busy
);

  localparam int unsigned BitW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned InitW = $clog2(INIT_CYCLES + 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(OUT_W - 1);
  localparam logic [InitW-1:0] LastInit = InitW'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [2:0]       load_cnt_q, load_cnt_d;
  logic [InitW-1:0] init_cnt_q, init_cnt_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [24:0]      seed_sh_q, seed_sh_d;  // chunks still to be sent, next chunk in [4:0]
  logic [4:0]       d3_q, d3_d;
  logic [4:0]       tk_q, tk_d;
  logic             load_q, init_q, busy_q;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] rnd_data_q, rnd_data_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic             accept;
  logic             stall;

  // Handshake and clock-enable decode
  always_comb begin
    seed_ready = !rst && ((state_q == StIdle) || (state_q == StRun));
    accept     = seed_valid && seed_ready;
    // Hold the last bit back while the output register is still occupied
    stall      = (state_q == StRun) && (bit_cnt_q == LastBit) && rnd_valid_q && !rnd_ready;
    nlfsr3_ce  = (state_q == StLoad) || (state_q == StInit) || ((state_q == StRun) && !stall);
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    init_cnt_d  = init_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    seed_sh_d   = seed_sh_q;
    d3_d        = '0;
    tk_d        = tk_q;
    acc_d       = acc_q;
    rnd_data_d  = rnd_data_q;
    rnd_valid_d = rnd_valid_q;

    if (rnd_valid_q && rnd_ready) begin
      rnd_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
      end
      StLoad: begin
        if (load_cnt_q == 3'd5) begin
          state_d    = StInit;
          init_cnt_d = '0;
        end else begin
          load_cnt_d = load_cnt_q + 3'd1;
          d3_d       = seed_sh_q[4:0];
          seed_sh_d  = seed_sh_q >> 5;
        end
      end
      StInit: begin
        if (init_cnt_q == LastInit) begin
          state_d   = StRun;
          bit_cnt_d = '0;
          acc_d     = '0;
        end else begin
          init_cnt_d = init_cnt_q + InitW'(1);
        end
      end
      StRun: begin
        if (nlfsr3_ce) begin
          acc_d[bit_cnt_q] = o_warbler;
          if (bit_cnt_q == LastBit) begin
            rnd_data_d  = acc_d;
            rnd_valid_d = 1'b1;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A seed accept (IDLE or RUN) restarts loading; any partial or pending word is dropped
    if (accept) begin
      state_d     = StLoad;
      load_cnt_d  = '0;
      seed_sh_d   = seed_data[29:5];
      d3_d        = seed_data[4:0];
      tk_d        = seed_tk;
      bit_cnt_d   = '0;
      acc_d       = '0;
      rnd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      load_cnt_q  <= '0;
      init_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      seed_sh_q   <= '0;
      d3_q        <= '0;
      tk_q        <= '0;
      load_q      <= 1'b0;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      init_cnt_q  <= init_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      seed_sh_q   <= seed_sh_d;
      d3_q        <= d3_d;
      tk_q        <= tk_d;
      load_q      <= (state_d == StLoad);
      init_q      <= (state_d == StInit);
      busy_q      <= (state_d == StLoad) || (state_d == StInit);
      acc_q       <= acc_d;
      rnd_data_q  <= rnd_data_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

  assign load      = load_q;
  assign init      = init_q;
  assign busy      = busy_q;
  assign d3        = d3_q;
  assign tk        = tk_q;
  assign rnd_data  = rnd_data_q;
  assign rnd_valid = rnd_valid_q;

  a_load_has_ce: assert property (@(posedge clk) disable iff (rst) load |-> nlfsr3_ce);
  a_init_has_ce: assert property (@(posedge clk) disable iff (rst) init |-> nlfsr3_ce);
  a_busy_no_seed: assert property (@(posedge clk) disable iff (rst) busy |-> !seed_ready);

endmodule

// File: tb/tb_nlfsr3_seq_ctrl.sv
// Bench for nlfsr3_seq_ctrl: a stand-in NLFSR3 drives o_warbler, and expected words come
// from stepping that register model straight from the seed.
module tb_nlfsr3_seq_ctrl;

  localparam int unsigned IC = 4;
  localparam int unsigned W  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         seed_valid = 1'b0;
  logic         seed_ready;
  logic [29:0]  seed_data = '0;
  logic [4:0]   seed_tk = '0;
  logic         nlfsr3_ce, load, init;
  logic [4:0]   d3, tk;
  logic         o_warbler;
  logic         rnd_valid;
  logic         rnd_ready = 1'b0;
  logic [W-1:0] rnd_data;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [29:0]  nst = '0;
  int           run_pos = 0;
  logic         pat_mode = 1'b0;
  logic [7:0]   pat_bits = 8'hB9;  // pattern 1,0,0,1,1,1,0,1 with the first bit at [0]
  logic [7:0]   got_q[$];
  logic [7:0]   exp_q[$];
  logic [22:0]  outs;

  always #5 clk = ~clk;

  nlfsr3_seq_ctrl #(.INIT_CYCLES(IC), .OUT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_data  (seed_data),
    .seed_tk    (seed_tk),
    .nlfsr3_ce  (nlfsr3_ce),
    .load       (load),
    .init       (init),
    .d3         (d3),
    .tk         (tk),
    .o_warbler  (o_warbler),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .rnd_data   (rnd_data),
    .busy       (busy)
  );

  assign outs = {nlfsr3_ce, load, init, d3, tk, rnd_valid, rnd_data, busy};

  function automatic logic warb(input logic [29:0] s, input logic [4:0] t);
    return ^(s[4:0] ^ (s[14:10] & s[24:20]) ^ s[29:25] ^ t);
  endfunction

  function automatic logic [29:0] nstep(input logic [29:0] s, input logic [4:0] t,
                                        input logic ini);
    logic [4:0] fb;
    fb = s[4:0] ^ {s[8:5], s[9]} ^ (s[19:15] & ~s[24:20]) ^ t;
    if (ini) fb = fb ^ {4'b0, warb(s, t)};
    return {fb, s[29:5]};
  endfunction

  // Stand-in NLFSR3 plus output-handshake monitor
  always @(posedge clk) begin
    if (nlfsr3_ce) begin
      if (load) nst <= {d3, nst[29:5]};
      else      nst <= nstep(nst, tk, init);
      if (load || init) run_pos <= 0;
      else              run_pos <= run_pos + 1;
    end
    if (!rst && rnd_valid && rnd_ready) got_q.push_back(rnd_data);
  end

  assign o_warbler = pat_mode ? pat_bits[run_pos[2:0]] : warb(nst, tk);

  // Golden word stream straight from the seed: 6 loads, IC init rounds, then keystream
  task automatic build_exp(input logic [29:0] sd, input logic [4:0] t, input int n);
    logic [29:0] s;
    logic [7:0]  w;
    exp_q.delete();
    s = '0;
    for (int k = 0; k < 6; k++) s = {sd[5*k +: 5], s[29:5]};
    for (int i = 0; i < int'(IC); i++) s = nstep(s, t, 1'b1);
    for (int j = 0; j < n; j++) begin
      for (int b = 0; b < 8; b++) begin
        w[b] = warb(s, t);
        s = nstep(s, t, 1'b0);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    seed_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_seed(input logic [29:0] sd, input logic [4:0] t);
    seed_data = sd;
    seed_tk = t;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rnd_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic collect(input int n, input int budget, input logic rand_ready, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      rnd_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    rnd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    seed_valid = 1'b1;
    tick();
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    checks++;
    if (seed_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_seed_ready_low: got %b want 0", seed_ready);
    end
    seed_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (seed_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_seed_ready: got %b want 1", seed_ready);
    end
  endtask

  task automatic test_load();
    logic [29:0] sd;
    logic [4:0]  ch;
    int          busy_cnt;
    sd = 30'h2AAA_AAAA;
    do_reset();
    seed_data = sd;
    seed_tk = 5'h13;
    seed_valid = 1'b1;
    #1;
    checks++;
    if (seed_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_accept_ready: got %b want 1", seed_ready);
    end
    tick();
    seed_valid = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      ch = sd[5*k +: 5];
      checks++;
      if ({load, nlfsr3_ce, init, d3, tk, seed_ready} !== {1'b1, 1'b1, 1'b0, ch, 5'h13, 1'b0})
      begin
        failures++;
        $display("FAIL load_cycle%0d: got load=%b ce=%b init=%b d3=%h tk=%h sr=%b want d3=%h tk=13",
                 k, load, nlfsr3_ce, init, d3, tk, seed_ready, ch);
      end
      busy_cnt += int'(busy);
      tick();
    end
    for (int i = 0; i < int'(IC); i++) begin
      checks++;
      if ({load, init, nlfsr3_ce, seed_ready} !== 4'b0110) begin
        failures++;
        $display("FAIL init_cycle%0d: got load=%b init=%b ce=%b sr=%b want 0,1,1,0",
                 i, load, init, nlfsr3_ce, seed_ready);
      end
      busy_cnt += int'(busy);
      tick();
    end
    checks++;
    if ({busy, init, load, nlfsr3_ce, seed_ready} !== 5'b00011) begin
      failures++;
      $display("FAIL run_entry: got busy=%b init=%b load=%b ce=%b sr=%b want 0,0,0,1,1",
               busy, init, load, nlfsr3_ce, seed_ready);
    end
    checks++;
    if (busy_cnt != 6 + int'(IC)) begin
      failures++;
      $display("FAIL busy_length: got %0d want %0d", busy_cnt, 6 + IC);
    end
  endtask

  task automatic test_pattern();
    int         v1, v2, ce_low;
    logic [7:0] dat1, dat2;
    do_reset();
    pat_mode = 1'b1;
    rnd_ready = 1'b1;
    v1 = -1;
    v2 = -1;
    dat1 = '0;
    dat2 = '0;
    ce_low = 0;
    send_seed($urandom(), 5'($urandom()));
    for (int c = 1; c <= 30; c++) begin
      if (rnd_valid) begin
        if (v1 < 0) begin
          v1 = c;
          dat1 = rnd_data;
        end else if (v2 < 0) begin
          v2 = c;
          dat2 = rnd_data;
        end
      end
      if (!nlfsr3_ce) ce_low++;
      tick();
    end
    checks++;
    if (v1 != 7 + int'(IC) + int'(W) || dat1 !== 8'hB9) begin
      failures++;
      $display("FAIL pattern_first_word: got T+%0d data=%h want T+%0d data=b9",
               v1, dat1, 7 + IC + W);
    end
    checks++;
    if (v2 != v1 + int'(W) || dat2 !== 8'hB9) begin
      failures++;
      $display("FAIL pattern_second_word: got T+%0d data=%h want T+%0d data=b9",
               v2, dat2, v1 + W);
    end
    checks++;
    if (ce_low != 0) begin
      failures++;
      $display("FAIL pattern_ce_steady: got %0d low cycles want 0", ce_low);
    end
    pat_mode = 1'b0;
    rnd_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [29:0] sd;
    logic [4:0]  t;
    logic        ok;
    do_reset();
    rnd_ready = 1'b0;
    got_q.delete();
    sd = $urandom();
    t = 5'($urandom());
    build_exp(sd, t, 4);
    send_seed(sd, t);
    wait_valid(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_first_valid: got timeout want rnd_valid");
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({nlfsr3_ce, rnd_valid} !== {(i < 7), 1'b1}) begin
        failures++;
        $display("FAIL stall_cycle%0d: got ce=%b valid=%b want ce=%b valid=1",
                 i, nlfsr3_ce, rnd_valid, (i < 7));
      end
      tick();
    end
    rnd_ready = 1'b1;
    #1;
    checks++;
    if (nlfsr3_ce !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ce: got %b want 1", nlfsr3_ce);
    end
    collect(4, 200, 1'b0, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_collect: got %0d words want 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL stall_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reseed();
    logic [29:0] sda, sdb;
    logic [4:0]  ta, tb;
    logic [7:0]  a0;
    logic        ok;
    do_reset();
    rnd_ready = 1'b0;
    got_q.delete();
    sda = $urandom();
    ta = 5'($urandom());
    sdb = $urandom();
    tb = 5'($urandom());
    build_exp(sda, ta, 1);
    a0 = exp_q[0];
    send_seed(sda, ta);
    wait_valid(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reseed_first_valid: got timeout want rnd_valid");
    end
    tick();
    tick();
    tick();
    seed_data = sdb;
    seed_tk = tb;
    seed_valid = 1'b1;
    rnd_ready = 1'b1;
    #1;
    checks++;
    if ({seed_ready, rnd_valid} !== 2'b11) begin
      failures++;
      $display("FAIL reseed_offer: got sr=%b valid=%b want 1,1", seed_ready, rnd_valid);
    end
    tick();
    seed_valid = 1'b0;
    rnd_ready = 1'b0;
    checks++;
    if ({rnd_valid, load, d3, tk} !== {1'b0, 1'b1, sdb[4:0], tb}) begin
      failures++;
      $display("FAIL reseed_restart: got valid=%b load=%b d3=%h tk=%h want 0,1,%h,%h",
               rnd_valid, load, d3, tk, sdb[4:0], tb);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== a0) begin
      failures++;
      $display("FAIL reseed_handshake: got %0d words first=%h want 1 word %h",
               got_q.size(), got_q[0], a0);
    end
    build_exp(sdb, tb, 3);
    collect(4, 200, 1'b0, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reseed_collect: got %0d words want 4", got_q.size());
    end
    for (int i = 1; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i-1]) begin
        failures++;
        $display("FAIL reseed_word%0d: got %h want %h", i, got_q[i], exp_q[i-1]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [29:0] sd;
    logic [4:0]  t;
    logic        ok;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      send_seed($urandom(), 5'($urandom()));
      // Now in T+1; abort at T+3 (3rd LOAD cycle) or T+8 (INIT)
      for (int i = 0; i < ((s == 0) ? 2 : 7); i++) tick();
      rst = 1'b1;
      tick();
      checks++;
      if (outs !== '0 || seed_ready !== 1'b0) begin
        failures++;
        $display("FAIL abort%0d_outputs: got %h sr=%b want 0 sr=0", s, outs, seed_ready);
      end
      rst = 1'b0;
      got_q.delete();
      sd = $urandom();
      t = 5'($urandom());
      build_exp(sd, t, 3);
      send_seed(sd, t);
      collect(3, 200, 1'b1, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL abort%0d_collect: got %0d words want 3", s, got_q.size());
      end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL abort%0d_word%0d: got %h want %h", s, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_long();
    logic [29:0] sd;
    logic [4:0]  t;
    logic        ok;
    do_reset();
    got_q.delete();
    sd = $urandom();
    t = 5'($urandom());
    build_exp(sd, t, 1000);
    send_seed(sd, t);
    collect(1000, 30000, 1'b1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL long_collect: got %0d words want 1000", got_q.size());
    end
    for (int i = 0; i < 1000 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL long_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_pattern();
    test_stall();
    test_reseed();
    test_reset_abort();
    test_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nlfsr3_seq_ctrl.md
# nlfsr3_seq_ctrl

Sequencer that drives the NLFSR3 warbler stage. It accepts a 30-bit seed and 5-bit tweak over a valid/ready handshake and shifts the seed into the six 5-bit NLFSR3 cells. It then runs a fixed number of init rounds and collects the `o_warbler` keystream bits into OUT_W-bit words on a valid/ready output. It sits between the TRNG seed/conditioning logic and the NLFSR3 instance, owning every NLFSR3 control input.

## Interface
- INIT_CYCLES, 54, number of init-round clocks after loading (≥1)
- OUT_W, 8, bits per output word (2..32)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seed_valid  in  1  seed/tweak offered
- seed_ready  out  1  seed accepted when seed_valid && seed_ready
- seed_data  in  30  seed; chunk k = seed_data[5k+4:5k], k=0..5
- seed_tk  in  5  tweak, latched with seed
- nlfsr3_ce  out  1  NLFSR3 clock enable
- load  out  1  NLFSR3 load select (d3 into C5)
- init  out  1  NLFSR3 init-phase flag
- d3  out  5  load data to NLFSR3
- tk  out  5  latched tweak to NLFSR3
- o_warbler  in  1  NLFSR3 keystream bit (combinational from current state)
- rnd_valid  out  1  output word valid
- rnd_ready  in  1  output word consumed when rnd_valid && rnd_ready
- rnd_data  out  OUT_W  output word; first collected bit is bit 0
- busy  out  1  high in LOAD or INIT

## Operation
- FSM states: IDLE, LOAD, INIT, RUN.
- IDLE:
  - seed_ready=1; all NLFSR3 controls 0.
  - On accept: latch seed_data and seed_tk (tk updates the next cycle), chunk counter:=0, go to LOAD.
- LOAD, 6 cycles:
  - load=1, nlfsr3_ce=1, d3=chunk[counter], counter increments.
  - Chunk 0 goes first and ends in C0; chunk 5 ends in C5.
  - After counter=5 go to INIT.
- INIT, INIT_CYCLES cycles:
  - init=1, nlfsr3_ce=1, load=0.
  - o_warbler is ignored.
  - Then go to RUN with bit counter:=0.
- RUN:
  - Each cycle with nlfsr3_ce=1, sample o_warbler into accumulator bit[bit_cnt], then bit_cnt++.
  - On the OUT_W-th bit, move the full word, including that bit, into the rnd_data register; set rnd_valid=1; bit_cnt:=0.
  - Backpressure: in RUN, nlfsr3_ce = !(bit_cnt==OUT_W-1 && rnd_valid && !rnd_ready). No bit is ever lost or duplicated.
  - rnd_valid clears on handshake unless a new word is loaded the same cycle (then stays 1 with new data).
- Reseed in RUN:
  - seed_ready=1 in RUN.
  - Accept discards the partial accumulator, clears rnd_valid (pending word dropped; a simultaneous rnd handshake still counts as consumed), goes to LOAD.
- seed_ready=0 in LOAD and INIT; seed_valid is ignored there.
- tk holds the latched tweak from accept until the next accept.

## Timing
- Reset, checked the cycle after rst is sampled high:
  - state IDLE; nlfsr3_ce=load=init=0; d3=0, tk=0, rnd_data=0, rnd_valid=0, busy=0.
  - seed_ready=0 while rst=1 and 1 the first cycle after release.
- rst mid-LOAD/INIT/RUN aborts to IDLE with the same values. The partial seed is not resumed.
- Accept in cycle T:
  - LOAD in T+1..T+6.
  - INIT in T+7..T+6+INIT_CYCLES.
  - RUN from T+7+INIT_CYCLES.
  - First rnd_valid at T+7+INIT_CYCLES+OUT_W.
- Steady state with rnd_ready=1: one word every OUT_W cycles. nlfsr3_ce never drops.
- Stall: ce drops only while the accumulator holds OUT_W-1 bits and the output register is full and unconsumed. ce returns the same cycle rnd_ready rises.
- All outputs are registered except seed_ready and nlfsr3_ce (decoded from state and registers).

## Test plan
- Reset then seed 30'h2AAA_AAAA, tk=5'h13 accepted at T:
  - d3 sequence 0A,15,0A,15,0A,15 with load=1 in T+1..T+6.
  - tk=13 from T+1.
  - busy=1 for 6+INIT_CYCLES cycles.
- Run with INIT_CYCLES=4, OUT_W=8, o_warbler forced to pattern 1,0,0,1,1,1,0,1:
  - rnd_data=8'hB9 at T+19.
  - Next word 8 cycles later.
- Hold rnd_ready=0 for 20 cycles after the first word:
  - nlfsr3_ce low once 7 bits are accumulated.
  - On release, next word equals the golden model with no skipped bits.
- Reseed in RUN mid-word, with a simultaneous rnd handshake:
  - handshake counts; rnd_valid=0 next cycle; LOAD restarts.
  - No partial word is emitted.
- Assert rst in the 3rd LOAD cycle and in INIT:
  - all outputs reach reset values next cycle.
  - A fresh seed then produces output identical to a clean run.
- Long run, 1000 words, against the NLFSR3 golden model with random rnd_ready:
  - word stream matches exactly.
